touch_btn_events: RTL



---
 rtl/touch_pkg.sv | 18 +
 rtl/btn_debounce_fsm.sv | 107 ++++++++++
 rtl/touch_btn_events.sv | 58 +++++
 3 files changed

// File: rtl/touch_pkg.sv
// Shared encodings for the touch-button event block.
// No logic; pure declarations, no latency or backpressure.
package touch_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PEND_ON  = 2'd1,
        HELD     = 2'd2,
        PEND_OFF = 2'd3
    } btn_state_t;

    localparam int BTN_RIGHT = 0;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_UP    = 2;
    localparam int BTN_RSVD  = 3;
    localparam int NUM_BTN   = 4;

endpackage

// File: rtl/btn_debounce_fsm.sv
// One button: 2-flop synchronizer, tick-based debounce, press/release/repeat pulses.
// Outputs registered, one cycle after the completing tick; no backpressure (pulses are fire-and-forget).
module btn_debounce_fsm
    import touch_pkg::*;
#(
    parameter int DEBOUNCE_MS     = 8,
    parameter int REPEAT_DELAY_MS = 400,
    parameter int REPEAT_RATE_MS  = 100,
    parameter int CNT_W           = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic pressed,
    output logic released,
    output logic repeated
);

    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_MS - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY_MS - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE_MS - 1);

    logic             s1;
    logic             sync;
    btn_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             rep;
    logic [CNT_W-1:0] lim;

    assign lim = rep ? RATE_LAST : DELAY_LAST;

    // A sync change always wins over a tick arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1       <= 1'b0;
            sync     <= 1'b0;
            state    <= IDLE;
            cnt      <= '0;
            rep      <= 1'b0;
            level    <= 1'b0;
            pressed  <= 1'b0;
            released <= 1'b0;
            repeated <= 1'b0;
        end else begin
            s1       <= raw;
            sync     <= s1;
            pressed  <= 1'b0;
            released <= 1'b0;
            repeated <= 1'b0;
            case (state)
                IDLE: begin
                    if (sync) begin
                        state <= PEND_ON;
                        cnt   <= '0;
                    end
                end
                PEND_ON: begin
                    if (!sync) begin
                        state <= IDLE;
                    end else if (tick) begin
                        if (cnt == DB_LAST) begin
                            state   <= HELD;
                            cnt     <= '0;
                            rep     <= 1'b0;
                            level   <= 1'b1;
                            pressed <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                HELD: begin
                    if (!sync) begin
                        state <= PEND_OFF;
                        cnt   <= '0;
                    end else if (tick) begin
                        if (cnt == lim) begin
                            repeated <= 1'b1;
                            cnt      <= '0;
                            rep      <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                PEND_OFF: begin
                    // rep survives the bounce so a re-touch never looks like a new press.
                    if (sync) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (tick) begin
                        if (cnt == DB_LAST) begin
                            state    <= IDLE;
                            level    <= 1'b0;
                            released <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/touch_btn_events.sv
// Millisecond prescaler plus four debounced button channels producing levels and event pulses.
// Press latency 2 sync cycles + DEBOUNCE_MS ticks + 1; no backpressure.
module touch_btn_events
    import touch_pkg::*;
#(
    parameter int CLK_DIV         = 50000,
    parameter int DEBOUNCE_MS     = 8,
    parameter int REPEAT_DELAY_MS = 400,
    parameter int REPEAT_RATE_MS  = 100,
    parameter int CNT_W           = 10
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic [NUM_BTN-1:0] iButton_state,
    output logic [NUM_BTN-1:0] oBtn_level,
    output logic [NUM_BTN-1:0] oPress,
    output logic [NUM_BTN-1:0] oRelease,
    output logic [NUM_BTN-1:0] oRepeat,
    output logic               oTick
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] pcnt;
    logic          tick;

    assign tick = (pcnt == P_LAST);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            pcnt  <= '0;
            oTick <= 1'b0;
        end else begin
            pcnt  <= tick ? '0 : pcnt + 1'b1;
            oTick <= tick;
        end
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_debounce_fsm #(
            .DEBOUNCE_MS    (DEBOUNCE_MS),
            .REPEAT_DELAY_MS(REPEAT_DELAY_MS),
            .REPEAT_RATE_MS (REPEAT_RATE_MS),
            .CNT_W          (CNT_W)
        ) u_btn (
            .clk     (iCLK),
            .rst     (iRST),
            .tick    (tick),
            .raw     (iButton_state[g]),
            .level   (oBtn_level[g]),
            .pressed (oPress[g]),
            .released(oRelease[g]),
            .repeated(oRepeat[g])
        );
    end

endmodule
